// File: rtl/sram_burst_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: default widths and the
// controller state encoding.
package sram_burst_ctrl_pkg;

  localparam int DEF_BITS       = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LEN_WIDTH  = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry read-data buffer between the SRAM Q pins and the read stream.
// Push and pop may happen in the same cycle.
module sram_rd_fifo #(
  parameter int BITS = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [BITS-1:0] head,
  output logic [1:0]      count
);

  logic [BITS-1:0] mem [2];
  logic            rd_ptr;
  logic            wr_ptr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a single-port synchronous SRAM: write bursts from a
// valid/ready stream, read bursts to a backpressured valid/ready stream.
module sram_burst_ctrl
  import sram_burst_ctrl_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [BITS-1:0]       wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [BITS-1:0]       rd_data,
  output logic                  done,
  output logic                  sram_CEN,
  output logic                  sram_WEN,
  output logic [ADDR_WIDTH-1:0] sram_A,
  output logic [BITS-1:0]       sram_D,
  input  logic [BITS-1:0]       sram_Q
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic                  issue;
  logic                  wr_access;
  logic                  drain_done;
  logic [2:0]            occupancy;

  assign cmd_ready = (state == ST_IDLE);
  assign wr_ready  = (state == ST_WRITE);
  assign rd_valid  = (fifo_count != 2'd0);
  assign pop       = rd_valid && rd_ready;
  assign wr_access = (state == ST_WRITE) && wr_valid;

  // A read may issue only if its word is guaranteed a FIFO slot on arrival.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ST_READ) && (occupancy < 3'd2);

  // Finish on the cycle the last word leaves, so done lands right after it.
  assign drain_done = (state == ST_DRAIN) && !inflight &&
                      ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  sram_rd_fifo #(.BITS(BITS)) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (inflight),
    .push_data (sram_Q),
    .pop       (pop),
    .head      (rd_data),
    .count     (fifo_count)
  );

  always_comb begin
    sram_CEN = 1'b1;
    sram_WEN = 1'b1;
    sram_A   = '0;
    sram_D   = '0;
    if (wr_access) begin
      sram_CEN = 1'b0;
      sram_WEN = 1'b0;
      sram_A   = addr;
      sram_D   = wr_data;
    end else if (issue) begin
      sram_CEN = 1'b0;
      sram_A   = addr;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= cmd_write ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (wr_valid) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
